// File: rtl/zoom_2x_frame_controller.sv
// Frame sequencer around a 2x nearest-neighbour zoom core: raster-reads the source, starts the core, writes its 2x2 block.
// Latency: 4 cycles of overhead per source pixel plus core time; writes are registered (+1 cycle). No backpressure is applied to the core.
module zoom_2x_frame_controller #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int SRC_AW = 15,
    parameter int DST_AW = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              err,
    output logic [SRC_AW-1:0] src_rd_addr,
    input  logic [7:0]        src_rd_data,
    output logic              zoom_start,
    output logic [7:0]        zoom_pixel_in,
    input  logic [7:0]        zoom_pixel_out,
    input  logic              zoom_pixel_valid,
    input  logic [1:0]        zoom_pixel_count,
    input  logic              zoom_done,
    output logic              dst_wr_en,
    output logic [DST_AW-1:0] dst_wr_addr,
    output logic [7:0]        dst_wr_data
);

    localparam int XW = $clog2(SRC_W + 1);
    localparam int YW = $clog2(SRC_H + 1);
    localparam logic [DST_AW-1:0] DST_ROW = DST_AW'(2 * SRC_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_GO,
        S_COLLECT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [2:0]        wr_cnt;
    logic [SRC_AW-1:0] rd_addr;
    logic              x_last;
    logic              last_px;
    logic [DST_AW-1:0] blk_base;
    logic [DST_AW-1:0] pix_addr;

    assign x_last  = (x == XW'(SRC_W - 1));
    assign last_px = x_last && (y == YW'(SRC_H - 1));

    // Top-left of the 2x2 destination block: row 2y, column 2x.
    assign blk_base = ((DST_AW'(y) * DST_ROW) << 1) + (DST_AW'(x) << 1);
    assign pix_addr = blk_base
                    + (zoom_pixel_count[1] ? DST_ROW : '0)
                    + DST_AW'(zoom_pixel_count[0]);

    assign busy        = (state != S_IDLE) && (state != S_FIN);
    assign frame_done  = (state == S_FIN);
    assign zoom_start  = (state == S_GO);
    assign src_rd_addr = rd_addr;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_RD;
            S_RD:      state_nx = S_WAIT;
            S_WAIT:    state_nx = S_GO;
            S_GO:      state_nx = S_COLLECT;
            S_COLLECT: if (zoom_done) state_nx = S_NEXT;
            S_NEXT:    state_nx = last_px ? S_FIN : S_RD;
            S_FIN:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            x             <= '0;
            y             <= '0;
            wr_cnt        <= '0;
            rd_addr       <= '0;
            zoom_pixel_in <= '0;
            err           <= 1'b0;
            dst_wr_en     <= 1'b0;
            dst_wr_addr   <= '0;
            dst_wr_data   <= '0;
        end else begin
            state     <= state_nx;
            dst_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err     <= 1'b0;
                        x       <= '0;
                        y       <= '0;
                        rd_addr <= '0;
                    end
                end
                S_WAIT: zoom_pixel_in <= src_rd_data;
                S_GO:   wr_cnt <= '0;
                S_COLLECT: begin
                    if (zoom_pixel_valid) begin
                        dst_wr_en   <= 1'b1;
                        dst_wr_addr <= pix_addr;
                        dst_wr_data <= zoom_pixel_out;
                        wr_cnt      <= wr_cnt + 3'd1;
                    end
                    // A pixel landing with done still counts toward the block total.
                    if (zoom_done && ((wr_cnt + 3'(zoom_pixel_valid)) != 3'd4))
                        err <= 1'b1;
                end
                S_NEXT: begin
                    rd_addr <= rd_addr + 1'b1;
                    if (x_last) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/zoom_2x_frame_controller.md
Name: zoom_2x_frame_controller

Overview:
Frame-level sequencer in front of and behind nearest_neighbor_zoom_2x. It scans the source image in raster order from source RAM and hands each pixel to the zoom core with a start pulse. It collects the core's 4 output pixels and writes each one to the destination frame buffer at its 2x2 block position. One frame per start command; the destination image is 2*SRC_W x 2*SRC_H.

Parameters:
SRC_W, 160, source image width in pixels (>=1)
SRC_H, 120, source image height in pixels (>=1)
SRC_AW, 15, source address width (>= clog2(SRC_W*SRC_H))
DST_AW, 17, destination address width (>= clog2(4*SRC_W*SRC_H))

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  frame request; sampled only in IDLE
busy  out  1  high from the cycle after accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last destination write
err  out  1  sticky; set if the core signals done with fewer than 4 valid pixels
src_rd_addr  out  SRC_AW  source RAM read address
src_rd_data  in  8  source RAM data, valid 1 cycle after address (registered RAM)
zoom_start  out  1  one-cycle start pulse to zoom core
zoom_pixel_in  out  8  source pixel to core, held stable from zoom_start until core done
zoom_pixel_out  in  8  core output pixel
zoom_pixel_valid  in  1  core output pixel valid this cycle
zoom_pixel_count  in  2  index of core output pixel: bit0 = dx, bit1 = dy
zoom_done  in  1  core completion pulse
dst_wr_en  out  1  destination RAM write strobe
dst_wr_addr  out  DST_AW  destination RAM write address
dst_wr_data  out  8  destination RAM write data

Behaviour:
- Reset values: all outputs 0; state IDLE; x = y = 0; err cleared. Reset mid-frame aborts immediately with no further writes. err is cleared only by reset or an accepted start.
- States:
  - IDLE: on start, go to RD, set busy, clear err, x = y = 0.
  - RD: drive src_rd_addr = y*SRC_W + x; go to WAIT.
  - WAIT: capture src_rd_data into zoom_pixel_in; go to GO.
  - GO: zoom_start = 1 for exactly one cycle; go to COLLECT.
  - COLLECT: on each zoom_pixel_valid, write one pixel in the same cycle (registered outputs allowed, +1 cycle latency):
    - dst_wr_en = 1
    - dst_wr_data = zoom_pixel_out
    - dst_wr_addr = (2y + dy)*(2*SRC_W) + 2x + dx
  - On zoom_done, go to NEXT. A valid pixel arriving in the same cycle as done is still written.
  - If zoom_done arrives with a write count (including the same-cycle pixel) != 4, set err; the frame still continues.
  - NEXT: if x == SRC_W-1, set x = 0 and y = y+1, else x = x+1. If the pixel just finished was (SRC_W-1, SRC_H-1), go to FIN; otherwise go to RD.
  - FIN: frame_done = 1 for one cycle, busy = 0; go to IDLE.
- start while busy is ignored, with no restart.
- zoom_pixel_valid outside COLLECT is ignored; no write occurs.
- Duplicate zoom_pixel_count values within one block are written as received; the count mismatch is not checked beyond the total of 4.
- Address arithmetic is unsigned, computed at full DST_AW width with no wrap for legal parameters. Multiplication by constants is permitted; incremental address registers are also acceptable.
- Throughput: 4 cycles of overhead (RD, WAIT, GO, NEXT) plus core latency per source pixel.

Test Plan:
- SRC_W=4, SRC_H=2, core model returns 4 valid pixels (counts 0..3) 1 cycle after start, then done; source RAM holds 0x10..0x17. Expected: 32 writes; destination address 0,1,8,9 = 0x10; address 22,23,30,31 = 0x17; frame_done after the last write; err = 0.
- Pulse start again mid-frame. Expected: no restart; write sequence identical to the first scenario.
- Assert reset for one cycle after 5 writes. Expected: all outputs 0 the next cycle, no further writes; a later start produces a full clean frame from address 0.
- Core model returns only 3 valid pixels before done on source pixel (1,0). Expected: err = 1 and stays high; the frame completes with 31 writes; the next start clears err.
- Core model asserts done in the same cycle as its 4th valid pixel. Expected: that pixel is written (address (2y+1)*8 + 2x+1); no lost or duplicate writes.
- SRC_W=1, SRC_H=1, pixel 0xAB. Expected: writes to addresses 0,1,2,3 = 0xAB; busy high for the frame; frame_done a single pulse.
